// File: rtl/memory_access_controller_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// parameter defaults and the latency counter width.
package memory_access_controller_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
    localparam int unsigned DEFAULT_READ_LATENCY = 1;
    localparam int unsigned CNT_W                = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_controller_latency_counter.sv
// 4-bit load/decrement counter that times the READ phase; zero_o flags the
// last read cycle.
module latency_counter
    import memory_access_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/memory_access_controller.sv
// Multi-cycle memory access controller: accepts one load/fetch/store request
// at a time, drives the memory port and captures read data into IR or MDR.
module memory_access_controller
    import memory_access_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic                  req_fetch_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [DATA_WIDTH-1:0] mdr_o,
    output logic                  done_o,
    output logic                  misaligned_o
);

    // Counter is loaded with LATENCY-1 so that zero marks the final READ cycle.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic                  write_q;
    logic                  fetch_q;
    logic                  we_q;
    logic                  done_q;
    logic                  mis_q;

    logic accept;
    logic aligned;
    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;

    assign req_ready_o = (state_q == ST_IDLE) && reset;
    assign accept      = req_valid_i && req_ready_o;
    assign aligned     = !is_misaligned(req_addr_i[1:0]);
    assign cnt_load    = accept && aligned && !req_write_i;
    assign cnt_en      = (state_q == ST_READ) && !cnt_zero;

    latency_counter u_latency_counter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .value_i (LAT_LOAD),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            write_q <= 1'b0;
            fetch_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        write_q <= req_write_i;
                        fetch_q <= req_fetch_i;
                        if (!aligned) begin
                            mis_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (req_write_i) begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_WRITE: state_q <= ST_IDLE;
                ST_READ: begin
                    if (cnt_zero) begin
                        if (!write_q && fetch_q) begin
                            ir_q <= mem_rdata_i;
                        end else if (!write_q) begin
                            mdr_q <= mem_rdata_i;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign ir_o         = ir_q;
    assign mdr_o        = mdr_q;
    assign done_o       = done_q;
    assign misaligned_o = mis_q;

endmodule
